// File: rtl/ps2_host_tx.sv
// ps2_host_tx
//
// Host-to-device PS/2 transmitter. It accepts one command byte per handshake
// and performs the request-to-send sequence: the clock is inhibited, the start
// bit is asserted, and then the clock is released. It then shifts out eight
// data bits (LSB first), odd parity and the stop bit, in step with the clock
// that the device generates. It checks the device ACK and waits for the bus to
// go idle before it reports done. On a NACK or a timeout it reports an error
// instead. The pins are open-drain: an oe of 1 pulls the line low.
//
// Ports
//   clk          100 MHz system clock, rising edge
//   rst          asynchronous active-high reset
//   tx_data      command byte, sampled on an accepted handshake only
//   tx_valid     request to send tx_data
//   tx_ready     high only while idle; handshake = tx_valid && tx_ready
//   tx_busy      high whenever a transfer is in progress
//   tx_done      one-cycle pulse: device ACKed and the bus is idle again
//   tx_err       one-cycle pulse: NACK or timeout
//   PS2_clk_in   raw PS/2 clock pin
//   PS2_data_in  raw PS/2 data pin
//   PS2_clk_oe   1 pulls the PS/2 clock low, 0 releases it
//   PS2_data_oe  1 pulls the PS/2 data low, 0 releases it

module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int START_HOLD     = 16,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 1500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       PS2_clk_in,
  input  logic       PS2_data_in,
  output logic       PS2_clk_oe,
  output logic       PS2_data_oe
);

  localparam int DLY_MAX = (INHIBIT_CYCLES > START_HOLD) ? INHIBIT_CYCLES : START_HOLD;
  localparam int DLY_W   = $clog2(DLY_MAX + 1);
  localparam int FLT_W   = $clog2(FILTER_LEN + 1);
  localparam int TO_W    = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    SEND,
    ACK,
    WAIT_IDLE
  } state_t;

  // Input conditioning registers
  logic [1:0]       clkSync_q;
  logic [1:0]       dataSync_q;
  logic [FLT_W-1:0] clkFltCnt_q;
  logic [FLT_W-1:0] dataFltCnt_q;
  logic             clkFilt_q;
  logic             dataFilt_q;
  logic             clkFiltPrev_q;
  logic             fall;
  logic             timeout;

  // FSM and datapath registers
  state_t           state_q, state_d;
  logic [DLY_W-1:0] dlyCnt_q, dlyCnt_d;
  logic [TO_W-1:0]  tocnt_q, tocnt_d;
  logic [3:0]       bitcnt_q, bitcnt_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             par_q, par_d;
  logic             txReady_q, txReady_d;
  logic             txBusy_q, txBusy_d;
  logic             txDone_q, txDone_d;
  logic             txErr_q, txErr_d;
  logic             clkOe_q, clkOe_d;
  logic             dataOe_q, dataOe_d;

  // Two-flop synchronizers, followed by a stability filter. A filtered line
  // moves only after FILTER_LEN consecutive samples disagree with it. Any
  // sample that agrees with the current filtered value restarts the count,
  // which is what rejects short glitches. Both lines idle high, so they
  // reset to 1 so that no edge is seen after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clkSync_q     <= 2'b11;
      dataSync_q    <= 2'b11;
      clkFltCnt_q   <= '0;
      dataFltCnt_q  <= '0;
      clkFilt_q     <= 1'b1;
      dataFilt_q    <= 1'b1;
      clkFiltPrev_q <= 1'b1;
    end else begin
      clkSync_q     <= {clkSync_q[0], PS2_clk_in};
      dataSync_q    <= {dataSync_q[0], PS2_data_in};
      clkFiltPrev_q <= clkFilt_q;

      if (clkSync_q[1] == clkFilt_q) begin
        clkFltCnt_q <= '0;
      end else if (clkFltCnt_q == FLT_W'(FILTER_LEN - 1)) begin
        clkFilt_q   <= clkSync_q[1];
        clkFltCnt_q <= '0;
      end else begin
        clkFltCnt_q <= clkFltCnt_q + 1'b1;
      end

      if (dataSync_q[1] == dataFilt_q) begin
        dataFltCnt_q <= '0;
      end else if (dataFltCnt_q == FLT_W'(FILTER_LEN - 1)) begin
        dataFilt_q   <= dataSync_q[1];
        dataFltCnt_q <= '0;
      end else begin
        dataFltCnt_q <= dataFltCnt_q + 1'b1;
      end
    end
  end

  assign fall    = clkFiltPrev_q & ~clkFilt_q;
  assign timeout = (tocnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  // State and registered outputs. The reset is asynchronous, so both pins are
  // released at once when it is asserted mid-transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      dlyCnt_q  <= '0;
      tocnt_q   <= '0;
      bitcnt_q  <= '0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      txReady_q <= 1'b1;
      txBusy_q  <= 1'b0;
      txDone_q  <= 1'b0;
      txErr_q   <= 1'b0;
      clkOe_q   <= 1'b0;
      dataOe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      dlyCnt_q  <= dlyCnt_d;
      tocnt_q   <= tocnt_d;
      bitcnt_q  <= bitcnt_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      txReady_q <= txReady_d;
      txBusy_q  <= txBusy_d;
      txDone_q  <= txDone_d;
      txErr_q   <= txErr_d;
      clkOe_q   <= clkOe_d;
      dataOe_q  <= dataOe_d;
    end
  end

  // Next-state logic. tocnt_d defaults to 0, so the timeout counter clears on
  // every fall and in every state that does not count. A fall is checked
  // before the timeout, so a fall in the same cycle as the timeout wins.
  always_comb begin
    state_d  = state_q;
    dlyCnt_d = dlyCnt_q;
    tocnt_d  = '0;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    par_d    = par_q;
    clkOe_d  = clkOe_q;
    dataOe_d = dataOe_q;
    txDone_d = 1'b0;
    txErr_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        clkOe_d  = 1'b0;
        dataOe_d = 1'b0;
        if (tx_valid && txReady_q) begin
          state_d  = INHIBIT;
          shreg_d  = tx_data;
          par_d    = ~^tx_data;
          bitcnt_d = '0;
          dlyCnt_d = '0;
          clkOe_d  = 1'b1;
        end
      end

      INHIBIT: begin
        clkOe_d  = 1'b1;
        dataOe_d = 1'b0;
        if (dlyCnt_q == DLY_W'(INHIBIT_CYCLES - 1)) begin
          dlyCnt_d = '0;
          dataOe_d = 1'b1;
          state_d  = START;
        end else begin
          dlyCnt_d = dlyCnt_q + 1'b1;
        end
      end

      START: begin
        clkOe_d  = 1'b1;
        dataOe_d = 1'b1;
        if (dlyCnt_q == DLY_W'(START_HOLD - 1)) begin
          dlyCnt_d = '0;
          clkOe_d  = 1'b0;
          state_d  = SEND;
        end else begin
          dlyCnt_d = dlyCnt_q + 1'b1;
        end
      end

      // bitcnt_q holds the number of edges already consumed. Edges 1-8 carry
      // the data, edge 9 carries parity, and edge 10 releases the line for
      // the stop bit.
      SEND: begin
        clkOe_d = 1'b0;
        if (fall) begin
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q < 4'd8) begin
            dataOe_d = ~shreg_q[0];
            shreg_d  = {1'b0, shreg_q[7:1]};
          end else if (bitcnt_q == 4'd8) begin
            dataOe_d = ~par_q;
          end else begin
            dataOe_d = 1'b0;
            state_d  = ACK;
          end
        end else if (timeout) begin
          dataOe_d = 1'b0;
          txErr_d  = 1'b1;
          state_d  = IDLE;
        end else begin
          tocnt_d = tocnt_q + 1'b1;
        end
      end

      ACK: begin
        clkOe_d  = 1'b0;
        dataOe_d = 1'b0;
        if (fall) begin
          if (!dataFilt_q) begin
            state_d = WAIT_IDLE;
          end else begin
            txErr_d = 1'b1;
            state_d = IDLE;
          end
        end else if (timeout) begin
          txErr_d = 1'b1;
          state_d = IDLE;
        end else begin
          tocnt_d = tocnt_q + 1'b1;
        end
      end

      WAIT_IDLE: begin
        clkOe_d  = 1'b0;
        dataOe_d = 1'b0;
        if (clkFilt_q && dataFilt_q) begin
          txDone_d = 1'b1;
          state_d  = IDLE;
        end else if (fall) begin
          tocnt_d = '0;
        end else if (timeout) begin
          txErr_d = 1'b1;
          state_d = IDLE;
        end else begin
          tocnt_d = tocnt_q + 1'b1;
        end
      end

      default: begin
        clkOe_d  = 1'b0;
        dataOe_d = 1'b0;
        state_d  = IDLE;
      end
    endcase

    txReady_d = (state_d == IDLE);
    txBusy_d  = (state_d != IDLE);
  end

  assign tx_ready    = txReady_q;
  assign tx_busy     = txBusy_q;
  assign tx_done     = txDone_q;
  assign tx_err      = txErr_q;
  assign PS2_clk_oe  = clkOe_q;
  assign PS2_data_oe = dataOe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Testbench for ps2_host_tx. The timing parameters are scaled down so the run
// stays short. A behavioural device model generates the PS/2 clock, samples
// the frame on each rising edge and then ACKs or NACKs it. The expected frame
// is computed from the byte with plain arithmetic.

module tb_ps2_host_tx;

   localparam int INH = 200;
   localparam int SH  = 16;
   localparam int FL  = 8;
   localparam int TO  = 2000;
   localparam int H   = 40;

   logic       clk;
   logic       rst;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       tx_busy;
   logic       tx_done;
   logic       tx_err;
   logic       PS2_clk_in;
   logic       PS2_data_in;
   logic       PS2_clk_oe;
   logic       PS2_data_oe;

   logic devClk;
   logic devData;
   logic glitch;

   int checks;
   int errors;
   int cycleCnt;
   int doneCnt;
   int errCnt;
   int bothCnt;

   ps2_host_tx #(
      .INHIBIT_CYCLES(INH),
      .START_HOLD    (SH),
      .FILTER_LEN    (FL),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .tx_busy    (tx_busy),
      .tx_done    (tx_done),
      .tx_err     (tx_err),
      .PS2_clk_in (PS2_clk_in),
      .PS2_data_in(PS2_data_in),
      .PS2_clk_oe (PS2_clk_oe),
      .PS2_data_oe(PS2_data_oe)
   );

   // Open-drain bus: a line is low if either side pulls it low
   assign PS2_clk_in  = ~PS2_clk_oe & devClk & ~glitch;
   assign PS2_data_in = ~PS2_data_oe & devData;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   // Pulse monitor, sampled on the falling edge
   always @(negedge clk) begin
      if (tx_done) doneCnt <= doneCnt + 1;
      if (tx_err) errCnt <= errCnt + 1;
      if (tx_done && tx_err) bothCnt <= bothCnt + 1;
   end

   // Global watchdog
   initial begin
      repeat (60000) @(posedge clk);
      $display("[TB] FAIL watchdog: got no end of test, required end within 60000 cycles");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Reference frame as the device should see it: start, data LSB first,
   // odd parity, stop
   function automatic logic [10:0] frameOf(input logic [7:0] b);
      logic [10:0] f;
      int ones;
      f = '0;
      ones = 0;
      for (int i = 0; i < 8; i++) begin
         f[i+1] = b[i];
         ones += int'(b[i]);
      end
      f[0]  = 1'b0;
      f[9]  = ((ones % 2) == 0);
      f[10] = 1'b1;
      return f;
   endfunction

   // Handshake one byte and time the request-to-send sequence. sendCyc is
   // the cycle in which the clock is released.
   task automatic applyStimulus(input logic [7:0] b, output int sendCyc);
      int n;
      int t0;
      int t1;
      int t2;
      @(negedge clk);
      n = 0;
      while (!tx_ready && n < 20000) begin
         @(negedge clk);
         n++;
      end
      tx_data  = b;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      t0 = cycleCnt;
      checkOutput("busyAfterHs", 32'(tx_busy), 32'd1);
      checkOutput("readyAfterHs", 32'(tx_ready), 32'd0);
      checkOutput("clkOeAfterHs", 32'(PS2_clk_oe), 32'd1);
      checkOutput("dataOeAfterHs", 32'(PS2_data_oe), 32'd0);
      n = 0;
      while (!PS2_data_oe && n < INH + 50) begin
         @(negedge clk);
         n++;
      end
      t1 = cycleCnt;
      checkOutput("inhibitLen", 32'(t1 - t0), 32'(INH));
      n = 0;
      while (PS2_clk_oe && n < SH + 50) begin
         @(negedge clk);
         n++;
      end
      t2 = cycleCnt;
      checkOutput("startHold", 32'(t2 - t1), 32'(SH));
      checkOutput("clkLowMin", 32'(t2 - t0 >= INH + SH), 32'd1);
      sendCyc = t2;
   endtask

   // Device side: wait for request-to-send, clock ten bits, then ACK (data
   // low) or NACK (data high) on the eleventh clock
   task automatic deviceTransfer(input bit ack, input bit doGlitch, output logic [10:0] seen);
      int n;
      seen = '0;
      n = 0;
      while (!(PS2_data_oe && !PS2_clk_oe) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      checkOutput("rtsSeen", 32'(n < 5000), 32'd1);
      seen[0] = PS2_data_in;
      waitCycles(H);
      for (int k = 1; k <= 10; k++) begin
         devClk = 1'b0;
         waitCycles(H);
         devClk = 1'b1;
         waitCycles(2);
         seen[k] = PS2_data_in;
         if (doGlitch) begin
            waitCycles(8);
            glitch = 1'b1;
            waitCycles(3);
            glitch = 1'b0;
            waitCycles(H - 13);
         end else begin
            waitCycles(H - 2);
         end
      end
      devData = ack ? 1'b0 : 1'b1;
      waitCycles(H / 2);
      devClk = 1'b0;
      waitCycles(H);
      devClk = 1'b1;
      waitCycles(H / 2);
      devData = 1'b1;
      waitCycles(H);
   endtask

   task automatic runTransfer(input logic [7:0] b, input bit ack, input bit doGlitch);
      int sc;
      int d0;
      int e0;
      logic [10:0] seen;
      #1;
      d0 = doneCnt;
      e0 = errCnt;
      applyStimulus(b, sc);
      deviceTransfer(ack, doGlitch, seen);
      waitCycles(5);
      #1;
      checkOutput("frame", 32'(seen), 32'(frameOf(b)));
      checkOutput("rxByte", 32'(seen[8:1]), 32'(b));
      checkOutput("oddParity", 32'(^seen[9:1]), 32'd1);
      checkOutput("doneCount", 32'(doneCnt - d0), ack ? 32'd1 : 32'd0);
      checkOutput("errCount", 32'(errCnt - e0), ack ? 32'd0 : 32'd1);
      checkOutput("readyAfter", 32'(tx_ready), 32'd1);
      checkOutput("busyAfter", 32'(tx_busy), 32'd0);
      checkOutput("clkOeAfter", 32'(PS2_clk_oe), 32'd0);
      checkOutput("dataOeAfter", 32'(PS2_data_oe), 32'd0);
   endtask

   initial begin
      int sc;
      int n;
      int te;
      int d0;
      int e0;
      logic [7:0] rb;
      logic [10:0] seenA;
      logic [10:0] seenB;

      checks   = 0;
      errors   = 0;
      cycleCnt = 0;
      doneCnt  = 0;
      errCnt   = 0;
      bothCnt  = 0;
      rst      = 1'b1;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      devClk   = 1'b1;
      devData  = 1'b1;
      glitch   = 1'b0;

      // Reset state
      waitCycles(3);
      checkOutput("rstReady", 32'(tx_ready), 32'd1);
      checkOutput("rstBusy", 32'(tx_busy), 32'd0);
      checkOutput("rstDone", 32'(tx_done), 32'd0);
      checkOutput("rstErr", 32'(tx_err), 32'd0);
      checkOutput("rstClkOe", 32'(PS2_clk_oe), 32'd0);
      checkOutput("rstDataOe", 32'(PS2_data_oe), 32'd0);
      rst = 1'b0;
      waitCycles(20);

      $display("[TB] send 0xED and 0xF4 with ACK");
      runTransfer(8'hED, 1'b1, 1'b0);
      runTransfer(8'hF4, 1'b1, 1'b0);

      $display("[TB] random bytes");
      for (int i = 0; i < 4; i++) begin
         rb = 8'($urandom_range(0, 255));
         runTransfer(rb, 1'b1, 1'b0);
      end

      $display("[TB] NACK");
      runTransfer(8'h3C, 1'b0, 1'b0);

      $display("[TB] no device, timeout");
      #1;
      d0 = doneCnt;
      e0 = errCnt;
      applyStimulus(8'h5A, sc);
      n = 0;
      while (!tx_err && n < 3 * TO) begin
         @(negedge clk);
         n++;
      end
      te = cycleCnt;
      checkOutput("timeoutLatency", 32'(te - sc), 32'(TO));
      checkOutput("timeoutReady", 32'(tx_ready), 32'd1);
      checkOutput("timeoutClkOe", 32'(PS2_clk_oe), 32'd0);
      checkOutput("timeoutDataOe", 32'(PS2_data_oe), 32'd0);
      checkOutput("timeoutNoDone", 32'(tx_done), 32'd0);
      waitCycles(3);
      #1;
      checkOutput("timeoutErrCount", 32'(errCnt - e0), 32'd1);
      checkOutput("timeoutDoneCount", 32'(doneCnt - d0), 32'd0);

      $display("[TB] reset after the 5th device edge");
      d0 = doneCnt;
      e0 = errCnt;
      applyStimulus(8'h00, sc);
      waitCycles(H);
      for (int k = 1; k <= 5; k++) begin
         devClk = 1'b0;
         waitCycles(H);
         if (k < 5) begin
            devClk = 1'b1;
            waitCycles(H);
         end
      end
      checkOutput("dataOeBeforeRst", 32'(PS2_data_oe), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("asyncRstDataOe", 32'(PS2_data_oe), 32'd0);
      checkOutput("asyncRstClkOe", 32'(PS2_clk_oe), 32'd0);
      checkOutput("asyncRstBusy", 32'(tx_busy), 32'd0);
      devClk = 1'b1;
      waitCycles(3);
      rst = 1'b0;
      waitCycles(20);
      #1;
      checkOutput("rstNoDone", 32'(doneCnt - d0), 32'd0);
      checkOutput("rstNoErr", 32'(errCnt - e0), 32'd0);
      checkOutput("rstReadyAgain", 32'(tx_ready), 32'd1);
      runTransfer(8'hFF, 1'b1, 1'b0);

      $display("[TB] hold tx_valid with 0xAA during a 0xED transfer");
      #1;
      d0 = doneCnt;
      e0 = errCnt;
      @(negedge clk);
      n = 0;
      while (!tx_ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      tx_data  = 8'hED;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_data = 8'hAA;
      fork
         deviceTransfer(1'b1, 1'b0, seenA);
         begin
            n = 0;
            while (!tx_done && n < 5000) begin
               @(negedge clk);
               n++;
            end
            checkOutput("holdDoneSeen", 32'(tx_done), 32'd1);
            checkOutput("holdReadyInDone", 32'(tx_ready), 32'd1);
            @(negedge clk);
            checkOutput("holdAaAccepted", 32'(tx_busy), 32'd1);
            checkOutput("holdAaClkOe", 32'(PS2_clk_oe), 32'd1);
            tx_valid = 1'b0;
         end
      join
      checkOutput("holdFrameED", 32'(seenA), 32'(frameOf(8'hED)));
      deviceTransfer(1'b1, 1'b0, seenB);
      waitCycles(5);
      #1;
      checkOutput("holdFrameAA", 32'(seenB), 32'(frameOf(8'hAA)));
      checkOutput("holdDoneCount", 32'(doneCnt - d0), 32'd2);
      checkOutput("holdErrCount", 32'(errCnt - e0), 32'd0);

      $display("[TB] 3-cycle clock glitches");
      runTransfer(8'hA5, 1'b1, 1'b1);
      runTransfer(8'h69, 1'b1, 1'b1);

      #1;
      checkOutput("doneErrTogether", 32'(bothCnt), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
